trainer: RTL
============

# trainer

Training sequencer for one `product` neuron. It holds a small dataset of (arguments, target) samples and runs `EPOCHS` training passes; each sample gets one forward transaction, an error of target minus result, and one backward transaction. It then runs one evaluation pass with `train` low and reports the worst absolute error. It sits between a host/load stream and a single `product` instance, driving all four of that instance's streams.

## Interface
- `N`, 2: argument count per sample.
- `W`, 8: argument width.
- `R`, 16: result, error and target width (signed, two's complement).
- `DEPTH`, 4: sample memory entries.
- `EPOCHS`, 25: training passes per run; 0 is legal.
- `TOL`, 5: pass threshold on max absolute error.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `sample_valid`  in  1  load handshake.
- `sample_ready`  out  1  load handshake.
- `sample_data`  in  R+N*W  {target, args[N-1:0]}.
- `start`  in  1  single-cycle run request.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished and results valid.
- `pass`  out  1  `max_error` < `TOL`.
- `max_error`  out  R  worst absolute error of the evaluation pass, unsigned.
- `train`  out  1  to product.
- `argument_valid`  out  1  to product.
- `argument_ready`  in  1  from product.
- `argument_data`  out  N*W  to product.
- `result_valid`  in  1  from product.
- `result_ready`  out  1  to product.
- `result_data`  in  R  from product.
- `error_valid`  out  1  to product.
- `error_ready`  in  1  from product.
- `error_data`  out  R  to product.
- `propagate_valid`  in  1  from product.
- `propagate_ready`  out  1  to product.
- `propagate_data`  in  N*R  from product; discarded.

## Operation
- **Reset values.** All outputs are 0 except `sample_ready`. Sample count is 0, the state is IDLE and `done` is 0.
- **Loading.** `sample_ready` = (state is IDLE or DONE) and count < `DEPTH`. Each handshake writes entry[count] and increments count. When count = `DEPTH`, further samples are refused and count stays at `DEPTH`.
- **Start.**
  - `start` is accepted only in IDLE or DONE with count > 0; otherwise it is ignored.
  - On acceptance: clear `done`, `pass` and `max_error`, set epoch to 0 and sample index to 0, and go to FWD.
  - `train` = 1 if `EPOCHS` > 0, else 0.
- **State machine:**
  - FWD: `argument_valid` = 1 with entry[index] args. On handshake, go to RES.
  - RES: `result_ready` = 1. On handshake, register err = sat_R(target − result) and go to ERR when training, or to EVAL when evaluating.
  - ERR: `error_valid` = 1 with the registered err. On handshake, go to PRP.
  - PRP: `propagate_ready` = 1. On handshake, drop the data and advance.
  - EVAL: compute |err|, saturating −2^(R−1) to 2^(R−1)−1. `max_error` = max(`max_error`, |err|). Advance in 1 cycle.
  - Advance: index+1. If index = count−1, index wraps to 0 and:
    - while training: epoch+1, and when epoch reaches `EPOCHS`, `train` = 0 and the evaluation pass begins;
    - while evaluating: go to DONE.
  - DONE: `busy` = 0, `done` = 1, `pass` valid. Stays until the next accepted start or `reset`.
- **Arithmetic.** Subtraction is done in R+1 bits, then saturated to R-bit signed.
- **`busy`** = 1 in every state except IDLE and DONE.
- **Mid-run `reset`.** Immediate asynchronous return to reset values; samples are lost. `product` shares `reset` and is cleared at the same time.
- **Mid-run `start`.** Ignored.

## Timing
- All valids and data are registered.
- Payload and valid are held stable until the handshake.
- Valids never depend combinationally on the readies.
- Each state lasts at least 1 cycle. With zero-stall partners:
  - training sample: 4 cycles (FWD, RES, ERR, PRP);
  - evaluation sample: 3 cycles (FWD, RES, EVAL).
- Run time with no stalls = count·(4·EPOCHS + 3) cycles from the accepting edge to `done` = 1.
- `train` changes only on entry to FWD, never while a product transaction is outstanding.
- `done`, `pass` and `max_error` update on the same edge.

## Test plan
- **Reset and load.** Assert `reset` asynchronously mid-cycle.
  - Outputs go to 0 at once; `sample_ready` = 1.
  - Load 4 samples: count = 4, then `sample_ready` = 0 and a 5th `sample_valid` is not accepted.
  - `start` with count = 0 leaves `busy` = 0.
- **Sequence with a stub product** (result always 0x0010), `EPOCHS` = 1, targets {ff00, 007f, ff00, 007f}.
  - `error_data` sequence: fef0, 006f, fef0, 006f.
  - 4 backward, then 4 forward with `train` = 0.
  - `max_error` = 0x0110, `pass` = 0, `done` after exactly 4·(4+3) = 28 cycles.
- **Saturation.**
  - Target 7fff, result 8000 gives `error_data` 7fff.
  - Target 8000, result 7fff gives 8000 and `max_error` 7fff.
- **Backpressure.** Randomly stall `argument_ready`, `error_ready`, `result_valid` and `propagate_valid`.
  - Payloads stay stable while valid is high.
  - The transaction sequence is identical to the unstalled run.
- **Mid-run events.**
  - `reset` while in ERR: `error_valid` drops immediately; a later `start` is ignored until reload.
  - `start` while `busy`: no effect.
- **Integration** with `product` (N=2, S=2, SEED=0), `EPOCHS` = 25.
  - Args {0000, 00ff, ff00, ffff}, targets {ff00, 007f, ff00, 007f}.
  - Required: `done` = 1, `max_error` < 5, `pass` = 1.

Source files
------------

// File: rtl/trainer.sv
// Training sequencer for one product neuron: loads a small sample set, runs EPOCHS
// forward/backward passes, then one evaluation pass reporting the worst absolute error.
module trainer #(
    parameter int N      = 2,
    parameter int W      = 8,
    parameter int R      = 16,
    parameter int DEPTH  = 4,
    parameter int EPOCHS = 25,
    parameter int TOL    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [R+N*W-1:0] sample_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [R-1:0]     max_error,
    output logic             train,
    output logic             argument_valid,
    input  logic             argument_ready,
    output logic [N*W-1:0]   argument_data,
    input  logic             result_valid,
    output logic             result_ready,
    input  logic [R-1:0]     result_data,
    output logic             error_valid,
    input  logic             error_ready,
    output logic [R-1:0]     error_data,
    input  logic             propagate_valid,
    output logic             propagate_ready,
    input  logic [N*R-1:0]   propagate_data
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = $clog2(EPOCHS + 1) + 1;

    typedef enum logic [2:0] {IDLE, FWD, RES, ERR, PRP, EVAL, DONE} state_t;

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic [IW-1:0]    idx_r;
    logic [EW-1:0]    epoch_r;
    logic [R-1:0]     err_r;
    logic [R-1:0]     tgt_mem_r [DEPTH];
    logic [N*W-1:0]   arg_mem_r [DEPTH];

    logic             idle_s;
    logic             load_fire_s;
    logic             start_ok_s;
    logic             last_s;
    logic [R-1:0]     abs_s;
    logic [R-1:0]     new_max_s;
    logic             unused_prop_s;

    // Target minus result in R+1 bits, clamped to the signed R-bit range.
    function automatic logic [R-1:0] sat_sub(input logic [R-1:0] a, input logic [R-1:0] b);
        logic [R:0] d;
        d = {a[R-1], a} - {b[R-1], b};
        if (d[R] != d[R-1]) begin
            sat_sub = d[R] ? {1'b1, {(R-1){1'b0}}} : {1'b0, {(R-1){1'b1}}};
        end else begin
            sat_sub = d[R-1:0];
        end
    endfunction

    // Magnitude of a signed value; the most negative code maps to the largest positive one.
    function automatic logic [R-1:0] abs_sat(input logic [R-1:0] e);
        if (!e[R-1]) begin
            abs_sat = e;
        end else if (e == {1'b1, {(R-1){1'b0}}}) begin
            abs_sat = {1'b0, {(R-1){1'b1}}};
        end else begin
            abs_sat = (~e) + R'(1);
        end
    endfunction

    assign idle_s          = (state_r == IDLE) || (state_r == DONE);
    assign sample_ready    = idle_s && (count_r < CW'(DEPTH));
    assign load_fire_s     = sample_valid && sample_ready;
    assign start_ok_s      = start && idle_s && (count_r != CW'(0));
    assign last_s          = (CW'(idx_r) == count_r - CW'(1));
    assign abs_s           = abs_sat(err_r);
    assign new_max_s       = (abs_s > max_error) ? abs_s : max_error;
    assign busy            = !idle_s;
    assign argument_valid  = (state_r == FWD);
    assign result_ready    = (state_r == RES);
    assign error_valid     = (state_r == ERR);
    assign propagate_ready = (state_r == PRP);
    assign error_data      = err_r;
    assign unused_prop_s   = ^propagate_data;

    // Sample memory write port; contents are meaningless once count is cleared.
    always_ff @(posedge clock) begin
        if (load_fire_s) begin
            tgt_mem_r[count_r[IW-1:0]] <= sample_data[R+N*W-1 -: R];
            arg_mem_r[count_r[IW-1:0]] <= sample_data[N*W-1:0];
        end
    end

    // Run sequencer: load counting, forward/result/error/propagate handshakes, evaluation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            count_r       <= CW'(0);
            idx_r         <= IW'(0);
            epoch_r       <= EW'(0);
            err_r         <= R'(0);
            train         <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            max_error     <= R'(0);
            argument_data <= (N*W)'(0);
        end else begin
            if (load_fire_s) begin
                count_r <= count_r + CW'(1);
            end
            case (state_r)
                IDLE, DONE: begin
                    if (start_ok_s) begin
                        state_r       <= FWD;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        max_error     <= R'(0);
                        epoch_r       <= EW'(0);
                        idx_r         <= IW'(0);
                        train         <= (EPOCHS > 0);
                        argument_data <= arg_mem_r[IW'(0)];
                    end
                end
                FWD: begin
                    if (argument_ready) state_r <= RES;
                end
                RES: begin
                    if (result_valid) begin
                        err_r   <= sat_sub(tgt_mem_r[idx_r], result_data);
                        state_r <= train ? ERR : EVAL;
                    end
                end
                ERR: begin
                    if (error_ready) state_r <= PRP;
                end
                PRP: begin
                    if (propagate_valid) begin
                        state_r <= FWD;
                        if (last_s) begin
                            idx_r         <= IW'(0);
                            argument_data <= arg_mem_r[IW'(0)];
                            epoch_r       <= epoch_r + EW'(1);
                            // Final training epoch: the next forward pass is evaluation.
                            if (epoch_r == EW'(EPOCHS - 1)) train <= 1'b0;
                        end else begin
                            idx_r         <= idx_r + IW'(1);
                            argument_data <= arg_mem_r[idx_r + IW'(1)];
                        end
                    end
                end
                EVAL: begin
                    max_error <= new_max_s;
                    if (last_s) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        pass    <= (new_max_s < R'(TOL));
                    end else begin
                        state_r       <= FWD;
                        idx_r         <= idx_r + IW'(1);
                        argument_data <= arg_mem_r[idx_r + IW'(1)];
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
